// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by a small byte FIFO; queued bytes go out back-to-back,
// LSB first, idle-high line.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_line,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;

    logic push_c;
    logic pop_c;
    logic bit_end_c;

    // Handshake, pop decision and next FIFO level
    always_comb begin
        bit_end_c = (clk_cnt == CNT_LAST);
        push_c    = i_valid && o_ready;
        pop_c     = (level != '0) &&
                    ((state == IDLE) ||
                     ((state == STOP) && bit_end_c && (bit_idx == STOP_LAST)));
        level_nxt = level;
        if (push_c && !pop_c) begin
            level_nxt = level + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Storage is not reset; pointers and level define what is valid
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            o_ready <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level   <= level_nxt;
            o_ready <= (level_nxt != LVL_FULL);
        end
    end

    assign o_fifo_level = level;

    // Frame sequencer; o_line is registered on each state/bit transition
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            o_line  <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_line  <= 1'b1;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (pop_c) begin
                        shift  <= mem[rd_ptr];
                        o_line <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        o_line  <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            o_line  <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            o_line  <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_c) begin
                        clk_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop_c) begin
                                shift  <= mem[rd_ptr];
                                o_line <= 1'b0;
                                state  <= START;
                            end else begin
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_line <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
